// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder_if
// Description : Start/done handshake and operand/result bundle for
//               seq_chunk_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder
// Description : Multi-cycle ripple-carry adder, CHUNK bits per clock through
//               one reused CHUNK-bit slice; start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_chunk_adder_if.slave  bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cs;
  logic             w_c_out;
  logic             w_c_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_work_nxt;

  // Operands shift right each cycle so the active chunk is always at bit 0.
  assign w_ca              = r_a[CHUNK-1:0];
  assign w_cb              = r_b[CHUNK-1:0];
  assign {w_c_out, w_cs}   = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};
  assign w_c_msb           = w_cs[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];
  assign w_last            = (r_idx == IW'(N - 1));

  // Result chunks enter at the top; after N steps chunk 0 sits at bit 0.
  if (CHUNK == WIDTH) begin : g_single
    assign w_work_nxt = w_cs;
  end else begin : g_multi
    assign w_work_nxt = {w_cs, r_work[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_work  <= w_work_nxt;
          r_carry <= w_c_out;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_sum   <= w_work_nxt;
            r_cout  <= w_c_out;
            r_ovf   <= w_c_msb ^ w_c_out;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_work  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_chunk_adder
// Description : Scoreboard bench for seq_chunk_adder at CHUNK = 1, 4 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    time          t;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int C = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;
    localparam int N = W / C;

    seq_chunk_adder_if #(.WIDTH(W)) bus();
    exp_t q[$];
    int   n_done = 0;
    logic prev_done = 1'b0;

    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Predict at the accepting edge; DUT state still holds pre-edge values here.
    always @(posedge clk) begin : p_push
      exp_t         e;
      logic [W:0]   full;
      if (rst) begin
        q.delete();
      end else if (bus.start && !bus.busy) begin
        full   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (bus.a[W-1] == bus.b[W-1]) && (full[W-1] != bus.a[W-1]);
        e.t    = $time;
        q.push_back(e);
      end
    end

    always @(negedge clk) begin : p_pop
      exp_t e;
      if (bus.done) begin
        n_done++;
        chk($sformatf("c%0d_done_pulse", C), 32'(prev_done), 32'(0));
        if (q.size() == 0) begin
          chk($sformatf("c%0d_unexpected_done", C), 32'(q.size()), 32'(1));
        end else begin
          e = q.pop_front();
          chk($sformatf("c%0d_sum", C),     32'(bus.sum),      32'(e.sum));
          chk($sformatf("c%0d_cout", C),    32'(bus.cout),     32'(e.cout));
          chk($sformatf("c%0d_ovf", C),     32'(bus.overflow), 32'(e.ovf));
          chk($sformatf("c%0d_latency", C), 32'($time - e.t),  32'(N * 10 + 5));
        end
      end
      prev_done = bus.done;
    end
  end

  logic         done4, busy4, cout4, ovf4;
  logic [W-1:0] sum4;
  assign done4 = g_dut[1].bus.done;
  assign busy4 = g_dut[1].bus.busy;
  assign sum4  = g_dut[1].bus.sum;
  assign cout4 = g_dut[1].bus.cout;
  assign ovf4  = g_dut[1].bus.overflow;

  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done4) return;
      if (busy4) nbusy++;
    end
    chk("done_timeout", 32'(done4), 32'(1));
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc, nb;
    @(posedge clk); #2;
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    wait_done(cyc, nb);
    chk("latency", 32'(cyc), 32'(5));
    chk("busy_cycles", 32'(nb), 32'(4));
    chk("sum", 32'(sum4), 32'(es));
    chk("cout", 32'(cout4), 32'(ec));
    chk("overflow", 32'(ovf4), 32'(eo));
  endtask

  initial begin
    int cyc, nb;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy4), 32'(0));
    chk("rst_done", 32'(done4), 32'(0));
    chk("rst_sum",  32'(sum4),  32'(0));
    chk("rst_cout", 32'(cout4), 32'(0));
    chk("rst_ovf",  32'(ovf4),  32'(0));
    rst = 1'b0;

    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // start held through RUN and into DONE: second op begins straight from DONE
    @(posedge clk); #2;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
    wait_done(cyc, nb);
    chk("b2b_first_latency", 32'(cyc), 32'(5));
    chk("b2b_first_sum", 32'(sum4), 32'(16'hFFFF));
    chk("b2b_first_cout", 32'(cout4), 32'(1));
    wait_done(cyc, nb);
    #1 start = 1'b0;
    chk("b2b_gap", 32'(cyc), 32'(5));
    chk("b2b_second_sum", 32'(sum4), 32'(16'h1000));
    chk("b2b_second_cout", 32'(cout4), 32'(0));

    // asynchronous reset two cycles into RUN
    @(posedge clk); #2;
    a = 16'h0011; b = 16'h0022; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("run_busy", 32'(busy4), 32'(1));
    chk("run_sum_stable", 32'(sum4), 32'(16'h1000));
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy4), 32'(0));
    chk("arst_done", 32'(done4), 32'(0));
    chk("arst_sum",  32'(sum4),  32'(0));
    chk("arst_cout", 32'(cout4), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    repeat (12) begin
      @(posedge clk); #2;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (18) @(posedge clk);
    end
    repeat (20) @(posedge clk);

    chk("c1_queue_empty",  32'(g_dut[0].q.size()), 32'(0));
    chk("c4_queue_empty",  32'(g_dut[1].q.size()), 32'(0));
    chk("c16_queue_empty", 32'(g_dut[2].q.size()), 32'(0));
    chk("c1_ran",  32'(g_dut[0].n_done >= 12), 32'(1));
    chk("c16_ran", 32'(g_dut[2].n_done >= 12), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle ripple-carry adder; the sequential successor to the team's single-bit half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using one CHUNK-bit ripple-carry slice reused over WIDTH/CHUNK cycles.
- Start/done handshake; result registers hold their value until the next operation completes.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle. 1 <= CHUNK <= WIDTH. CHUNK == WIDTH gives a single-cycle add.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition. Sampled only when not busy.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- cin  input  1  carry-in. Captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/cout/overflow update.
- sum  output  WIDTH  result a+b+cin, modulo 2^WIDTH.
- cout  output  1  unsigned carry out of the MSB.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Let N = WIDTH/CHUNK.
- Reset (asynchronous, rst=1): FSM goes to IDLE. busy=0, done=0, sum=0, cout=0, overflow=0. Chunk index, working register and carry register all clear.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch a, b, cin into internal operand registers;
  - clear the working register;
  - idx := 0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - add chunk idx (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) of A and B plus the carry register;
  - write the CHUNK-bit result into the same bit positions of the working register;
  - carry register := chunk carry-out;
  - idx := idx+1.
- RUN, on the edge processing chunk N-1:
  - sum := final working value;
  - cout := final carry;
  - overflow := carry-into-MSB XOR cout, taken from bit CHUNK-1 of the last slice;
  - go to DONE.
- DONE: done=1 for exactly this one cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation) and goes to RUN.
  - Otherwise go to IDLE.
- busy=1 exactly while in RUN. start is ignored while busy; it is not queued.
- Latency: with start sampled at edge E, done is high during the cycle following edge E+N. Back-to-back throughput is one result per N+1 cycles.
- sum, cout and overflow change only on the completing edge (or on reset). They are stable at all other times, including during a subsequent RUN.
- Operand inputs may change freely after the accepting edge with no effect on the current result.
- Wrap-around: the sum is truncated to WIDTH bits. Carry out is reported only on cout.
- CHUNK == WIDTH: RUN lasts one cycle, so done follows the edge after acceptance.
- Reset mid-RUN: the operation is abandoned and outputs clear to 0. The first start after reset deasserts begins cleanly.
- rst has priority over start on any edge.

Test Plan:
- Reset, then WIDTH=16, CHUNK=4: a=0x1234, b=0x4321, cin=0, start pulse.
  -> busy high 4 cycles; done pulse on the 5th cycle; sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0.
  -> sum=0x0000, cout=1, overflow=0. The carry must ripple through all 4 chunks.
- a=0x7FFF, b=0x0001, cin=0.
  -> sum=0x8000, cout=0, overflow=1.
  - Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- a=0xFFFF, b=0xFFFF, cin=1.
  -> sum=0xFFFF, cout=1.
  - start held high through RUN is ignored.
  - Holding start in DONE starts the next add immediately: second done arrives exactly 5 cycles after the first.
- Assert rst two cycles into RUN.
  -> busy=0, done=0, sum=0 immediately (asynchronously).
  - A new add a=0x0003, b=0x0004 then yields sum=0x0007 with normal latency.
- Sweep CHUNK in {1, 4, 16} at WIDTH=16 with random operands against a reference a+b+cin.
  -> done latency is 16, 4 and 1 RUN cycles respectively; all results match.
